// File: rtl/fastbconv_q_to_bba_if.sv
// Handshake bundle for the q -> B∪Ba fast base converter.
// The producer drives in_valid/input_RNSpoly; the converter returns in_ready, out_valid and the result.
interface fastbconv_q_to_bba_if #(
    parameter int N_SLOTS       = 2,
    parameter int IN_BASIS_LEN  = 3,
    parameter int OUT_BASIS_LEN = 3,
    parameter int PRIME_BITS    = 6
);
    logic                                                   in_valid;
    logic                                                   in_ready;
    logic [N_SLOTS-1:0][IN_BASIS_LEN-1:0][PRIME_BITS-1:0]  input_RNSpoly;
    logic                                                   out_valid;
    logic [N_SLOTS-1:0][OUT_BASIS_LEN-1:0][PRIME_BITS-1:0] output_RNSpoly;

    modport master (
        output in_valid,
        output input_RNSpoly,
        input  in_ready,
        input  out_valid,
        input  output_RNSpoly
    );

    modport slave (
        input  in_valid,
        input  input_RNSpoly,
        output in_ready,
        output out_valid,
        output output_RNSpoly
    );
endinterface

// File: rtl/fastbconv_q_to_bba.sv
// Fast base conversion q -> B∪Ba without overflow correction (the q-multiple error is accepted).
// One input basis index is folded into every slot's accumulators per ACCUM cycle.
module fastbconv_q_to_bba #(
    parameter int          N_SLOTS       = 2,
    parameter int          PRIME_BITS    = 6,
    parameter int          IN_BASIS_LEN  = 3,
    parameter int          OUT_BASIS_LEN = 3,
    parameter int unsigned IN_BASIS  [IN_BASIS_LEN]  = '{17, 19, 23},
    parameter int unsigned OUT_BASIS [OUT_BASIS_LEN] = '{29, 31, 37},
    parameter int unsigned ZiLUT     [IN_BASIS_LEN]  = '{10, 7, 1},
    parameter int unsigned YMODB     [IN_BASIS_LEN][OUT_BASIS_LEN] =
        '{'{2, 3, 30}, '{14, 19, 21}, '{4, 13, 27}}
) (
    input  logic                clk,
    input  logic                reset,
    fastbconv_q_to_bba_if.slave bus
);
    localparam int PROD_W = 2 * PRIME_BITS;
    localparam int SUM_W  = PRIME_BITS + 1;
    localparam int IDX_W  = (IN_BASIS_LEN > 1) ? $clog2(IN_BASIS_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IN_BASIS_LEN - 1);

    typedef logic [PRIME_BITS-1:0] rns_residue_t;
    typedef rns_residue_t [N_SLOTS-1:0][IN_BASIS_LEN-1:0]  in_poly_t;
    typedef rns_residue_t [N_SLOTS-1:0][OUT_BASIS_LEN-1:0] out_poly_t;
    typedef enum logic [1:0] {IDLE, SCALE, ACCUM} state_t;

    state_t           r_state;
    in_poly_t         r_x;
    in_poly_t         r_z;
    out_poly_t        r_acc;
    out_poly_t        r_output;
    logic [IDX_W-1:0] r_idx;
    logic             r_out_valid;

    in_poly_t         w_z;
    out_poly_t        w_term;
    out_poly_t        w_acc_next;
    logic [SUM_W-1:0] w_sum   [N_SLOTS][OUT_BASIS_LEN];
    rns_residue_t     w_sel_z [N_SLOTS];
    rns_residue_t     w_sel_y [OUT_BASIS_LEN];

    assign bus.in_ready       = (r_state == IDLE);
    assign bus.out_valid      = r_out_valid;
    assign bus.output_RNSpoly = r_output;

    // z[k][i] = x[k][i] * (q/q_i)^-1 mod q_i, computed from the latched input.
    always_comb begin
        for (int k = 0; k < N_SLOTS; k++) begin
            for (int i = 0; i < IN_BASIS_LEN; i++) begin
                w_z[k][i] = rns_residue_t'((PROD_W'(r_x[k][i]) * PROD_W'(ZiLUT[i]))
                                           % PROD_W'(IN_BASIS[i]));
            end
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns the selects; otherwise a latch is inferred.
        w_sel_z = '{default: '0};
        w_sel_y = '{default: '0};
        for (int i = 0; i < IN_BASIS_LEN; i++) begin
            if (IDX_W'(i) == r_idx) begin
                for (int k = 0; k < N_SLOTS; k++) w_sel_z[k] = r_z[k][i];
                for (int j = 0; j < OUT_BASIS_LEN; j++) w_sel_y[j] = rns_residue_t'(YMODB[i][j]);
            end
        end
    end

    // Both addends are already below m_j, so one conditional subtract keeps acc < m_j.
    always_comb begin
        for (int k = 0; k < N_SLOTS; k++) begin
            for (int j = 0; j < OUT_BASIS_LEN; j++) begin
                w_term[k][j] = rns_residue_t'((PROD_W'(w_sel_z[k]) * PROD_W'(w_sel_y[j]))
                                              % PROD_W'(OUT_BASIS[j]));
                w_sum[k][j]  = SUM_W'(r_acc[k][j]) + SUM_W'(w_term[k][j]);
                w_acc_next[k][j] = (w_sum[k][j] >= SUM_W'(OUT_BASIS[j]))
                                 ? rns_residue_t'(w_sum[k][j] - SUM_W'(OUT_BASIS[j]))
                                 : rns_residue_t'(w_sum[k][j]);
            end
        end
    end

    // NOTE: r_x and r_z are data registers that are always rewritten before being read, so they carry no reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_idx       <= '0;
            r_output    <= '0;
            r_acc       <= '0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_x     <= bus.input_RNSpoly;
                        r_state <= SCALE;
                    end
                end
                SCALE: begin
                    r_z     <= w_z;
                    r_acc   <= '0;
                    r_idx   <= '0;
                    r_state <= ACCUM;
                end
                ACCUM: begin
                    r_acc <= w_acc_next;
                    if (r_idx == LAST_IDX) begin
                        r_idx       <= '0;
                        r_output    <= w_acc_next;
                        r_out_valid <= 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fastbconv_q_to_bba.sv
// Bench for fastbconv_q_to_bba: hand-computed vector table, randomized vectors against an arithmetic
// model, a streaming run with in_valid held high, and reset corner cases.
module tb_fastbconv_q_to_bba;
    localparam int NS     = 2;
    localparam int PB     = 6;
    localparam int IL     = 3;
    localparam int OL     = 3;
    localparam int LAT    = IL + 1;
    localparam int PERIOD = IL + 2;
    localparam int unsigned QB [IL] = '{17, 19, 23};
    localparam int unsigned MB [OL] = '{29, 31, 37};
    localparam int unsigned ZI [IL] = '{10, 7, 1};
    localparam int unsigned YM [IL][OL] = '{'{2, 3, 30}, '{14, 19, 21}, '{4, 13, 27}};

    typedef logic [NS-1:0][IL-1:0][PB-1:0] in_vec_t;
    typedef logic [NS-1:0][OL-1:0][PB-1:0] out_vec_t;
    typedef struct packed { in_vec_t x; out_vec_t y; } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    fastbconv_q_to_bba_if #(.N_SLOTS(NS), .IN_BASIS_LEN(IL), .OUT_BASIS_LEN(OL), .PRIME_BITS(PB)) bus ();

    fastbconv_q_to_bba #(
        .N_SLOTS(NS), .PRIME_BITS(PB), .IN_BASIS_LEN(IL), .OUT_BASIS_LEN(OL),
        .IN_BASIS(QB), .OUT_BASIS(MB), .ZiLUT(ZI), .YMODB(YM)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic in_vec_t mk_in(int a0, int a1, int a2, int b0, int b1, int b2);
        in_vec_t v;
        v[0][0] = PB'(a0); v[0][1] = PB'(a1); v[0][2] = PB'(a2);
        v[1][0] = PB'(b0); v[1][1] = PB'(b1); v[1][2] = PB'(b2);
        return v;
    endfunction

    function automatic out_vec_t mk_out(int a0, int a1, int a2, int b0, int b1, int b2);
        out_vec_t v;
        v[0][0] = PB'(a0); v[0][1] = PB'(a1); v[0][2] = PB'(a2);
        v[1][0] = PB'(b0); v[1][1] = PB'(b1); v[1][2] = PB'(b2);
        return v;
    endfunction

    // Golden fastBConv: sum of z_i * (q/q_i mod m_j), reduced once at the end.
    function automatic out_vec_t model(input in_vec_t x);
        out_vec_t    y;
        int unsigned s, z;
        for (int k = 0; k < NS; k++) begin
            for (int j = 0; j < OL; j++) begin
                s = 0;
                for (int i = 0; i < IL; i++) begin
                    z = (32'(x[k][i]) * ZI[i]) % QB[i];
                    s = s + z * YM[i][j];
                end
                y[k][j] = PB'(s % MB[j]);
            end
        end
        return y;
    endfunction

    function automatic in_vec_t rand_vec();
        in_vec_t v;
        for (int k = 0; k < NS; k++)
            for (int i = 0; i < IL; i++)
                v[k][i] = ($urandom_range(0, 3) == 0) ? PB'(QB[i] - 1) : PB'($urandom_range(0, QB[i] - 1));
        return v;
    endfunction

    function automatic bit in_range(input out_vec_t y);
        bit ok = 1'b1;
        for (int k = 0; k < NS; k++)
            for (int j = 0; j < OL; j++)
                if (32'(y[k][j]) >= MB[j]) ok = 1'b0;
        return ok;
    endfunction

    task automatic send(input in_vec_t v);
        int w = 0;
        while (!bus.in_ready && w < 20) begin
            tick();
            w++;
        end
        check("ready_before_send", 64'(bus.in_ready), 64'd1);
        bus.in_valid      = 1'b1;
        bus.input_RNSpoly = v;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 50) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t     tbl [4];
        int       lat;
        in_vec_t  v;
        out_vec_t last_y;
        bit       seen;

        tbl[0] = '{x: mk_in(0, 0, 0, 0, 0, 0),   y: mk_out(0, 0, 0, 0, 0, 0)};
        tbl[1] = '{x: mk_in(1, 0, 0, 1, 0, 0),   y: mk_out(20, 30, 4, 20, 30, 4)};
        tbl[2] = '{x: mk_in(16, 18, 22, 0, 1, 0), y: mk_out(9, 8, 20, 11, 9, 36)};
        tbl[3] = '{x: mk_in(0, 0, 1, 1, 1, 1),   y: mk_out(4, 13, 27, 6, 21, 30)};

        bus.in_valid      = 1'b0;
        bus.input_RNSpoly = '0;
        repeat (3) tick();
        reset = 1'b0;
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_in_ready", 64'(bus.in_ready), 64'd1);
        check("reset_output", 64'(bus.output_RNSpoly), 64'd0);

        for (int t = 0; t < 4; t++) begin
            send(tbl[t].x);
            wait_result(lat);
            check($sformatf("table%0d_latency", t), 64'(lat), 64'(LAT));
            check($sformatf("table%0d_data", t), 64'(bus.output_RNSpoly), 64'(tbl[t].y));
            tick();
            check($sformatf("table%0d_pulse_low", t), 64'(bus.out_valid), 64'd0);
        end
        repeat (6) tick();
        check("output_hold", 64'(bus.output_RNSpoly), 64'(tbl[3].y));

        for (int r = 0; r < 25; r++) begin
            v = rand_vec();
            send(v);
            wait_result(lat);
            check($sformatf("rand%0d_data", r), 64'(bus.output_RNSpoly), 64'(model(v)));
            check($sformatf("rand%0d_range", r), 64'(in_range(bus.output_RNSpoly)), 64'd1);
        end
        tick();

        begin
            in_vec_t q_in [$];
            int      last_ov = -1;
            int      n_res   = 0;
            bus.in_valid = 1'b1;
            for (int c = 0; c < 60; c++) begin
                if (bus.out_valid) begin
                    if (q_in.size() == 0) check("stream_unexpected_result", 64'd1, 64'd0);
                    else check("stream_data", 64'(bus.output_RNSpoly), 64'(model(q_in.pop_front())));
                    if (last_ov >= 0) check("stream_period", 64'(c - last_ov), 64'(PERIOD));
                    last_ov = c;
                    n_res++;
                end
                if (c < 45) begin
                    v = rand_vec();
                    bus.input_RNSpoly = v;
                    if (bus.in_ready) q_in.push_back(v);
                end else begin
                    bus.in_valid = 1'b0;
                end
                tick();
            end
            check("stream_drained", 64'(q_in.size()), 64'd0);
            check("stream_enough_results", 64'(n_res >= 8), 64'd1);
        end

        send(mk_in(5, 6, 7, 8, 9, 10));
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_out_valid", 64'(bus.out_valid), 64'd0);
        check("abort_output", 64'(bus.output_RNSpoly), 64'd0);
        check("abort_in_ready", 64'(bus.in_ready), 64'd1);
        seen = 1'b0;
        repeat (8) begin
            tick();
            if (bus.out_valid) seen = 1'b1;
        end
        check("abort_no_result", 64'(seen), 64'd0);
        send(mk_in(0, 0, 0, 0, 0, 0));
        wait_result(lat);
        check("after_abort_latency", 64'(lat), 64'(LAT));
        check("after_abort_data", 64'(bus.output_RNSpoly), 64'd0);
        tick();

        bus.in_valid      = 1'b1;
        bus.input_RNSpoly = mk_in(1, 2, 3, 4, 5, 6);
        reset             = 1'b1;
        tick();
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        check("reset_priority_idle", 64'(bus.in_ready), 64'd1);
        seen = 1'b0;
        repeat (8) begin
            tick();
            if (bus.out_valid) seen = 1'b1;
        end
        check("reset_priority_no_result", 64'(seen), 64'd0);

        last_y = model(mk_in(16, 18, 22, 16, 18, 22));
        send(mk_in(16, 18, 22, 16, 18, 22));
        wait_result(lat);
        check("all_max_data", 64'(bus.output_RNSpoly), 64'(last_y));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
